mmio_uart_tx: RTL

- Memory-mapped UART transmitter on the RISC_V core's data bus; consumes the core's load/store traffic in its address window.
- Turns stored bytes into an 8N1 serial stream on `tx`, so directed programs (e.g. factorial) can print results instead of relying on hierarchical probes.
- Reads are combinational so the single-cycle core completes a load in one cycle.
- Writes are buffered in a FIFO and drained by a bit-timing state machine.

---
 rtl/uart_pkg.sv | 16 +
 rtl/sync_fifo.sv | 52 +++++
 rtl/mmio_uart_tx.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions and the transmit FSM state type.
package uart_pkg;

    localparam logic [1:0] TXDATA_OFF = 2'd0;
    localparam logic [1:0] STATUS_OFF = 2'd1;
    localparam logic [1:0] IER_OFF    = 2'd2;

    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_BUSY  = 2;
    localparam int ST_OVF   = 3;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO. A push while full is accepted only
// when a pop frees a slot in the same cycle; a pop while empty is ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter for the core's data bus: combinational
// register reads, buffered TXDATA writes. Optional IER/irq via UART_TX_IRQ_EN.
module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int          CLK_DIV    = 4,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic        re,
    output logic [31:0] rdata,
    output logic        tx
`ifdef UART_TX_IRQ_EN
    ,
    output logic        irq
`endif
);
    localparam int BW = $clog2(CLK_DIV);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);

    uart_state_e state;
    logic [BW-1:0] baud;
    logic [2:0]    bit_idx;
    logic [7:0]    shift_reg;
    logic          overflow;

    logic          hit;
    logic [1:0]    off;
    logic          txdata_wr;
    logic          status_wr;
    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    fifo_dout;
    logic          pop;
    logic          tick;
    logic          busy;
    logic          unused_bits;

    assign hit         = (addr[31:4] == BASE_ADDR[31:4]);
    assign off         = addr[3:2];
    assign txdata_wr   = we & hit & (off == TXDATA_OFF);
    assign status_wr   = we & hit & (off == STATUS_OFF);
    assign tick        = (baud == BAUD_LAST);
    assign busy        = (state != IDLE);
    assign unused_bits = ^{addr[1:0], wdata[31:8]};

    // A byte leaves the FIFO either from IDLE or at the end of a stop bit,
    // which is what lets queued frames run with no idle gap.
    assign pop = ~fifo_empty & ((state == IDLE) | ((state == STOP) & tick));

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (txdata_wr),
        .pop   (pop),
        .din   (wdata[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            baud      <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            tx        <= 1'b1;
        end else begin
            if (state == IDLE || tick) baud <= '0;
            else                       baud <= baud + 1'b1;

            case (state)
                IDLE: if (pop) begin
                    shift_reg <= fifo_dout;
                    state     <= START;
                    tx        <= 1'b0;
                end
                START: if (tick) begin
                    state   <= DATA;
                    bit_idx <= '0;
                    tx      <= shift_reg[0];
                end
                DATA: if (tick) begin
                    if (bit_idx == 3'd7) begin
                        state <= STOP;
                        tx    <= 1'b1;
                    end else begin
                        bit_idx   <= bit_idx + 3'd1;
                        shift_reg <= shift_reg >> 1;
                        tx        <= shift_reg[1];
                    end
                end
                STOP: if (tick) begin
                    if (pop) begin
                        shift_reg <= fifo_dout;
                        state     <= START;
                        tx        <= 1'b0;
                    end else begin
                        state <= IDLE;
                        tx    <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A drop and a software clear in the same cycle keep the flag set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                overflow <= 1'b0;
        else if (txdata_wr & fifo_full & ~pop)   overflow <= 1'b1;
        else if (status_wr & wdata[3])           overflow <= 1'b0;
    end

`ifdef UART_TX_IRQ_EN
    logic ier;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ier <= 1'b0;
            irq <= 1'b0;
        end else begin
            if (we & hit & (off == IER_OFF)) ier <= wdata[0];
            irq <= ier & fifo_empty & ~busy;
        end
    end
`endif

    always_comb begin
        rdata = '0;
        if (re && hit) begin
            case (off)
                STATUS_OFF: begin
                    rdata[ST_FULL]  = fifo_full;
                    rdata[ST_EMPTY] = fifo_empty;
                    rdata[ST_BUSY]  = busy;
                    rdata[ST_OVF]   = overflow;
                end
`ifdef UART_TX_IRQ_EN
                IER_OFF: rdata[0] = ier;
`endif
                default: rdata = '0;
            endcase
        end
    end

endmodule
